param_seq_detector: RTL and testbench

PARAM_SEQ_DETECTOR -- requirements
Module: param_seq_detector

---
 rtl/param_seq_detector.sv | 68 ++++++
 tb/tb_param_seq_detector.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/param_seq_detector.sv
// Serial pattern detector with a runtime-loadable pattern, overlapping or
// non-overlapping matching, and a saturating match counter.
module param_seq_detector #(
  parameter int unsigned        PAT_W   = 4,
  parameter int unsigned        CNT_W   = 8,
  parameter logic [PAT_W-1:0]   RST_PAT = 4'b0110
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       d_in,
  input  logic                       d_valid,
  input  logic                       mode,
  input  logic                       pat_load,
  input  logic [PAT_W-1:0]           pattern,
  input  logic                       cnt_clr,
  output logic                       d_out,
  output logic [$clog2(PAT_W):0]     fill,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int unsigned FILL_W = $clog2(PAT_W) + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0] pat_reg;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] cand;
  logic             hit;
  logic             unused_hist_msb;

  // The oldest history bit shifts out on every consume and is never compared.
  assign unused_hist_msb = hist[PAT_W-1];

  always_comb begin
    cand = {hist[PAT_W-2:0], d_in};
    hit  = d_valid & ~pat_load & (fill >= FILL_LAST) & (cand == pat_reg);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_reg   <= RST_PAT;
      hist      <= '0;
      fill      <= '0;
      d_out     <= 1'b0;
      match_cnt <= '0;
    end else begin
      d_out <= hit;

      if (pat_load) begin
        pat_reg <= pattern;
        hist    <= '0;
        fill    <= '0;
      end else if (d_valid) begin
        hist <= cand;
        if (hit)
          fill <= mode ? FILL_FULL : '0;
        else if (fill != FILL_FULL)
          fill <= fill + 1'b1;
      end

      if (cnt_clr)
        match_cnt <= '0;
      else if (hit && match_cnt != '1)
        match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_param_seq_detector.sv
// Self-checking bench for param_seq_detector: per-cycle scoreboard against a
// behavioural model plus directed checks of the documented scenarios.
module tb_param_seq_detector;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             d_in;
  logic             d_valid;
  logic             mode;
  logic             pat_load;
  logic [PAT_W-1:0] pattern;
  logic             cnt_clr;
  logic             d_out;
  logic [2:0]       fill;
  logic [CNT_W-1:0] match_cnt;

  param_seq_detector #(
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W),
    .RST_PAT(4'b0110)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .d_in     (d_in),
    .d_valid  (d_valid),
    .mode     (mode),
    .pat_load (pat_load),
    .pattern  (pattern),
    .cnt_clr  (cnt_clr),
    .d_out    (d_out),
    .fill     (fill),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dout;
    int fill;
    int cnt;
  } exp_t;

  exp_t q[$];

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Model state
  logic [3:0] m_pat;
  logic [3:0] m_hist;
  int         m_fill;
  int         m_cnt;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    check({tag, "_dout"}, int'(d_out), e.dout);
    check({tag, "_fill"}, int'(fill), e.fill);
    check({tag, "_cnt"}, int'(match_cnt), e.cnt);
    if (d_out) pulses++;
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    rst = 1'b0; d_valid = 1'b1; d_in = 1'b1; mode = 1'b1;
    pat_load = 1'b1; pattern = 4'b1111; cnt_clr = 1'b0;
    m_pat = 4'b0110; m_hist = '0; m_fill = 0; m_cnt = 0;
    e.dout = 0; e.fill = 0; e.cnt = 0;
    q.push_back(e);
    @(posedge clk); #1;
    compare_out(tag);
    rst = 1'b1; d_valid = 1'b0; pat_load = 1'b0;
  endtask

  task automatic step(input string tag, input logic v, input logic b,
                      input logic md, input logic ld, input logic [3:0] p,
                      input logic clr);
    exp_t       e;
    logic [3:0] c;
    logic       h;
    d_valid = v; d_in = b; mode = md; pat_load = ld; pattern = p; cnt_clr = clr;
    c = {m_hist[2:0], b};
    h = v && !ld && (m_fill >= PAT_W - 1) && (c == m_pat);
    if (ld) begin
      m_pat = p; m_hist = '0; m_fill = 0;
    end else if (v) begin
      m_hist = c;
      if (h)                m_fill = md ? PAT_W : 0;
      else if (m_fill < PAT_W) m_fill = m_fill + 1;
    end
    if (clr)                          m_cnt = 0;
    else if (h && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
    e.dout = h ? 1 : 0; e.fill = m_fill; e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk); #1;
    compare_out(tag);
  endtask

  task automatic bits(input string tag, input logic md, input logic [15:0] seq,
                      input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, seq[i], md, 1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; d_in = 1'b0; d_valid = 1'b0; mode = 1'b1;
    pat_load = 1'b0; pattern = '0; cnt_clr = 1'b0;
    @(posedge clk); #1;

    do_reset("reset");

    // Overlapping: 0110110 -> two pulses
    pulses = 0;
    bits("ovl", 1'b1, 16'b0110110, 7);
    check("ovl_pulses", pulses, 2);
    check("ovl_cnt_final", int'(match_cnt), 2);

    // Non-overlapping: same stream -> one pulse, fill ends at 3
    do_reset("reset2");
    pulses = 0;
    bits("novl", 1'b0, 16'b0110110, 7);
    check("novl_pulses", pulses, 1);
    check("novl_cnt_final", int'(match_cnt), 1);
    check("novl_fill_final", int'(fill), 3);

    // Mid-stream load with a valid bit in the load cycle
    bits("preload", 1'b1, 16'b01, 2);
    step("load", 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
    check("load_fill_zero", int'(fill), 0);
    check("load_dout_zero", int'(d_out), 0);
    pulses = 0;
    bits("ld1011", 1'b1, 16'b1011, 4);
    check("ld1011_pulses", pulses, 1);
    check("ld1011_last_dout", int'(d_out), 1);

    // Idle cycles hold history
    step("load0110", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0);
    bits("idle_pre", 1'b1, 16'b011, 3);
    step("idle1", 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step("idle2", 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    check("idle_fill_hold", int'(fill), 3);
    bits("idle_post", 1'b1, 16'b0, 1);
    check("idle_post_pulse", int'(d_out), 1);

    // All-ones pattern, saturation and clear-vs-hit
    step("load1111", 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    pulses = 0;
    bits("ones", 1'b1, 16'b1111111111, 10);
    check("ones_pulses", pulses, 7);
    check("ones_sat", int'(match_cnt), 3);
    step("clr_hit", 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    check("clr_hit_cnt", int'(match_cnt), 0);
    check("clr_hit_dout", int'(d_out), 1);

    // Reset mid-sequence discards history
    do_reset("reset3");
    bits("rs_pre", 1'b1, 16'b011, 3);
    do_reset("reset_mid");
    check("rs_fill", int'(fill), 0);
    check("rs_dout", int'(d_out), 0);
    pulses = 0;
    bits("rs_post0", 1'b1, 16'b0, 1);
    check("rs_no_pulse", pulses, 0);
    bits("rs_post", 1'b1, 16'b110, 3);
    check("rs_pulse", pulses, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
    end

    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
